// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the 8-bit CPU control path:
//   - state_t    : control FSM state encoding (also exported on state_out)
//   - OP_*       : 4-bit opcode constants (instruction[7:4])
//   - ALU_*      : 3-bit ALU operation codes driven on alu_op
//   - is_illegal : flags the two unassigned opcodes (D, E)
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SHL   = 4'h6;
    localparam logic [3:0] OP_SHR   = 4'h7;
    localparam logic [3:0] OP_ADDI  = 4'h8;
    localparam logic [3:0] OP_ANDI  = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_LD    = 4'hB;
    localparam logic [3:0] OP_ST    = 4'hC;
    localparam logic [3:0] OP_ILL_D = 4'hD;
    localparam logic [3:0] OP_ILL_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SHL   = 3'b101;
    localparam logic [2:0] ALU_SHR   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_ILL_D) || (op == OP_ILL_E);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// -----------------------------------------------------------------------------
// ctrl_decoder
// Purely combinational opcode -> datapath level-control mapping.
// Ports:
//   opcode     in  [3:0]  opcode from the latched instruction register
//   alu_op     out [2:0]  ALU operation
//   alu_src    out        1 = immediate as ALU operand B
//   imm_signed out        1 = sign-extend the 4-bit immediate
//   mem_to_reg out        1 = register writeback sourced from data memory
// Opcodes without datapath activity (NOP, illegal, HALT) decode to all zero.
// -----------------------------------------------------------------------------
module ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       imm_signed,
    output logic       mem_to_reg
);

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        imm_signed = 1'b0;
        mem_to_reg = 1'b0;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            OP_SHL:  alu_op = ALU_SHL;
            OP_SHR:  alu_op = ALU_SHR;
            OP_ADDI: begin
                alu_op     = ALU_ADD;
                alu_src    = 1'b1;
                imm_signed = 1'b1;
            end
            OP_ANDI: begin
                alu_op     = ALU_AND;
                alu_src    = 1'b1;
            end
            OP_LDI: begin
                alu_op     = ALU_PASSB;
                alu_src    = 1'b1;
            end
            OP_LD: begin
                alu_op     = ALU_ADD;
                alu_src    = 1'b1;
                imm_signed = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_ST: begin
                alu_op     = ALU_ADD;
                alu_src    = 1'b1;
                imm_signed = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Multi-cycle control FSM for the 8-bit CPU. Sequences FETCH, DECODE, EXEC,
// MEM and WB around synchronous instruction/data memories and drives every
// datapath control input.
// Parameters:
//   FETCH_WAIT  instruction-memory read latency, cycles spent in FETCH (1-3)
//   LOAD_WAIT   data-memory read latency, cycles spent in MEM on LD (1-3)
// Ports:
//   clk          in         system clock, rising edge
//   reset        in         asynchronous, active-high; clears all state
//   run          in         level; leave IDLE / keep issuing while high
//   instruction  in  [7:0]  [7:4] opcode, [3:0] operand (used by datapath)
//   reg_write    out        one-cycle pulse in WB (not for NOP)
//   mem_write    out        one-cycle pulse in MEM for ST
//   pc_write     out        one-cycle pulse at instruction completion
//   alu_src      out        level, valid in EXEC/MEM/WB
//   imm_signed   out        level, valid in EXEC/MEM/WB
//   alu_op       out [2:0]  level, valid in EXEC/MEM/WB
//   mem_to_reg   out        level, valid in EXEC/MEM/WB
//   halted       out        high while in HALT
//   state_out    out [2:0]  current state encoding (debug)
//   illegal      out        sticky illegal-opcode flag (CTRL_ILLEGAL_TRAP_EN)
// Build option:
//   CTRL_ILLEGAL_TRAP_EN  defined   : opcodes D/E halt and set `illegal`
//                         undefined : opcodes D/E execute as NOP, no port
// -----------------------------------------------------------------------------
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int FETCH_WAIT = 1,
    parameter int LOAD_WAIT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instruction,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       alu_src,
    output logic       imm_signed,
    output logic [2:0] alu_op,
    output logic       mem_to_reg,
    output logic       halted,
    output logic [2:0] state_out
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    // Last count value of each wait window (counter starts at 0 on entry).
    localparam logic [1:0] FETCH_LAST = 2'(FETCH_WAIT - 1);
    localparam logic [1:0] LOAD_LAST  = 2'(LOAD_WAIT - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] wait_cnt;
    logic [3:0] ir_op;

    logic [2:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_imm_signed;
    logic       dec_mem_to_reg;
    logic       level_en;

    // The operand field is consumed by the datapath, not by control.
    logic unused_operand;
    assign unused_operand = ^instruction[3:0];

    // ------------------------------------------------------------------
    // State register, wait counter, instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ir_op    <= OP_NOP;
        end else begin
            state <= state_next;
            // Counter only runs while a wait state is held; any transition
            // clears it so the next window starts from zero.
            if ((state_next == state) && ((state == ST_FETCH) || (state == ST_MEM)))
                wait_cnt <= wait_cnt + 2'd1;
            else
                wait_cnt <= '0;
            if (state == ST_DECODE)
                ir_op <= instruction[7:4];
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if ((state == ST_DECODE) && is_illegal(instruction[7:4]))
            illegal <= 1'b1;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic. DECODE looks at the live instruction (the same
    // value being latched into ir_op); every later state uses ir_op.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run)
                    state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (wait_cnt == FETCH_LAST)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (instruction[7:4] == OP_HALT)
                    state_next = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (is_illegal(instruction[7:4]))
                    state_next = ST_HALT;
                else if (instruction[7:4] == OP_NOP)
                    state_next = ST_WB;
`else
                else if ((instruction[7:4] == OP_NOP) || is_illegal(instruction[7:4]))
                    state_next = ST_WB;
`endif
                else
                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if ((ir_op == OP_LD) || (ir_op == OP_ST))
                    state_next = ST_MEM;
                else
                    state_next = ST_WB;
            end
            ST_MEM: begin
                if (ir_op == OP_ST)
                    state_next = run ? ST_FETCH : ST_IDLE;
                else if (wait_cnt == LOAD_LAST)
                    state_next = ST_WB;
            end
            ST_WB: begin
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore: depends only on state and ir_op)
    // ------------------------------------------------------------------
    ctrl_decoder u_decoder (
        .opcode     (ir_op),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .imm_signed (dec_imm_signed),
        .mem_to_reg (dec_mem_to_reg)
    );

    assign level_en = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        halted     = 1'b0;
        alu_op     = '0;
        alu_src    = 1'b0;
        imm_signed = 1'b0;
        mem_to_reg = 1'b0;
        state_out  = state;

        if (level_en) begin
            alu_op     = dec_alu_op;
            alu_src    = dec_alu_src;
            imm_signed = dec_imm_signed;
            mem_to_reg = dec_mem_to_reg;
        end

        case (state)
            ST_MEM: begin
                // ST completes in its single MEM cycle; LD waits for data.
                if (ir_op == OP_ST) begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                end
            end
            ST_WB: begin
                pc_write  = 1'b1;
                reg_write = !((ir_op == OP_NOP) || is_illegal(ir_op));
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. A table-driven reference model turns
// each instruction into the expected per-cycle output trace (FETCH_WAIT fetch
// cycles, one decode cycle, then the class-specific execute/memory/writeback
// cycles) and every DUT cycle is compared against it.
// Build option CTRL_ILLEGAL_TRAP_EN is honoured the same way as in the RTL.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam int FETCH_WAIT = 1;
    localparam int LOAD_WAIT  = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] instruction;
    logic       reg_write, mem_write, pc_write, alu_src, imm_signed, mem_to_reg, halted;
    logic [2:0] alu_op;
    logic [2:0] state_out;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    always #5 clk = ~clk;

    control_unit #(
        .FETCH_WAIT (FETCH_WAIT),
        .LOAD_WAIT  (LOAD_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .alu_src     (alu_src),
        .imm_signed  (imm_signed),
        .alu_op      (alu_op),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .state_out   (state_out)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    // Observed vector: {state, reg_write, mem_write, pc_write,
    //                   alu_src, imm_signed, alu_op, mem_to_reg, halted}
    logic [12:0] obs;
    assign obs = {state_out, reg_write, mem_write, pc_write,
                  alu_src, imm_signed, alu_op, mem_to_reg, halted};

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    // Opcode map: {alu_src, imm_signed, alu_op[2:0], mem_to_reg}
    function automatic logic [5:0] levels(input logic [3:0] op);
        case (op)
            4'h1: return 6'b00_000_0;
            4'h2: return 6'b00_001_0;
            4'h3: return 6'b00_010_0;
            4'h4: return 6'b00_011_0;
            4'h5: return 6'b00_100_0;
            4'h6: return 6'b00_101_0;
            4'h7: return 6'b00_110_0;
            4'h8: return 6'b11_000_0;
            4'h9: return 6'b10_010_0;
            4'hA: return 6'b10_111_0;
            4'hB: return 6'b11_000_1;
            4'hC: return 6'b11_000_0;
            default: return 6'b00_000_0;
        endcase
    endfunction

    function automatic logic [12:0] vec(input int st, input logic rw, input logic mw,
                                        input logic pw, input logic [5:0] lv, input logic h);
        return {3'(st), rw, mw, pw, lv, h};
    endfunction

    function automatic logic traps(input logic [3:0] op);
`ifdef CTRL_ILLEGAL_TRAP_EN
        return (op == 4'hF) || (op == 4'hD) || (op == 4'hE);
`else
        return op == 4'hF;
`endif
    endfunction

    // Expected trace for one instruction starting with its first FETCH cycle.
    task automatic build(input logic [7:0] instr);
        logic [3:0] op;
        logic [5:0] lv;
        op = instr[7:4];
        lv = levels(op);
        exp_q.delete();
        for (int i = 0; i < FETCH_WAIT; i++) exp_q.push_back(vec(1, 0, 0, 0, 6'd0, 0));
        exp_q.push_back(vec(2, 0, 0, 0, 6'd0, 0));
        if (traps(op)) begin
            exp_q.push_back(vec(6, 0, 0, 0, 6'd0, 1));
        end else if (op == 4'h0 || op == 4'hD || op == 4'hE) begin
            exp_q.push_back(vec(5, 0, 0, 1, 6'd0, 0));
        end else if (op == 4'hC) begin
            exp_q.push_back(vec(3, 0, 0, 0, lv, 0));
            exp_q.push_back(vec(4, 0, 1, 1, lv, 0));
        end else if (op == 4'hB) begin
            exp_q.push_back(vec(3, 0, 0, 0, lv, 0));
            for (int i = 0; i < LOAD_WAIT; i++) exp_q.push_back(vec(4, 0, 0, 0, lv, 0));
            exp_q.push_back(vec(5, 1, 0, 1, lv, 0));
        end else begin
            exp_q.push_back(vec(3, 0, 0, 0, lv, 0));
            exp_q.push_back(vec(5, 1, 0, 1, lv, 0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; instruction = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL reset_hold: got %b want %b", obs, 13'd0);
        end
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 13'd0) begin
                errors++; $display("FAIL idle_run0: got %b want %b", obs, 13'd0);
            end
        end
        // Start an ADD and abort it with reset while in EXEC.
        run = 1'b1; instruction = 8'h14;
        repeat (2 + FETCH_WAIT) @(posedge clk);
        #1;
        checks++;
        if (obs !== vec(3, 0, 0, 0, levels(4'h1), 0)) begin
            errors++; $display("FAIL reset_pre_exec: got %b want %b", obs, vec(3, 0, 0, 0, levels(4'h1), 0));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL reset_async: got %b want %b", obs, 13'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL reset_no_pulse: got %b want %b", obs, 13'd0);
        end
        run = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 13'd0) begin
                errors++; $display("FAIL reset_release_idle: got %b want %b", obs, 13'd0);
            end
        end
    endtask

    // One instruction from IDLE; run is dropped right after leaving IDLE,
    // so the instruction must still complete and then return to IDLE.
    // The instruction input is scrambled once DECODE has sampled it.
    task automatic test_single(input logic [7:0] instr, input string name);
        run = 1'b1; instruction = instr;
        build(instr);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL %s cycle %0d: got %b want %b", name, k + 1, obs, exp_q[k]);
            end
            if (k == 0) run = 1'b0;
            if (k > FETCH_WAIT) instruction = 8'($urandom);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL %s return_idle: got %b want %b", name, obs, 13'd0);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [7:0] cur, nxt;
        logic [3:0] op;
        logic       last;
        op = 4'hF;
        while (traps(op)) op = 4'($urandom_range(0, 14));
        cur = {op, 4'($urandom)};
        run = 1'b1; instruction = cur;
        for (int i = 0; i < n; i++) begin
            op = 4'hF;
            while (traps(op)) op = 4'($urandom_range(0, 14));
            nxt = {op, 4'($urandom)};
            build(cur);
            for (int k = 0; k < exp_q.size(); k++) begin
                @(posedge clk); #1;
                checks++;
                if (obs !== exp_q[k]) begin
                    errors++; $display("FAIL b2b instr %0d (%h) cycle %0d: got %b want %b",
                                       i, cur, k + 1, obs, exp_q[k]);
                end
                last = (k == exp_q.size() - 1);
                if (last) begin
                    instruction = nxt;
                    run = (i == n - 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
                end else begin
                    run = 1'($urandom);
                    if (k > FETCH_WAIT) instruction = 8'($urandom);
                end
            end
            if (!run) begin
                @(posedge clk); #1;
                checks++;
                if (obs !== 13'd0) begin
                    errors++; $display("FAIL b2b idle after %0d: got %b want %b", i, obs, 13'd0);
                end
                run = 1'b1;
            end
            cur = nxt;
        end
        run = 1'b0;
    endtask

    task automatic test_halt(input logic [7:0] instr, input string name);
        logic [12:0] hv;
        hv = vec(6, 0, 0, 0, 6'd0, 1);
        run = 1'b1; instruction = instr;
        build(instr);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL %s cycle %0d: got %b want %b", name, k + 1, obs, exp_q[k]);
            end
            if (k > FETCH_WAIT) instruction = 8'($urandom);
        end
        repeat (6) begin
            run = 1'($urandom); instruction = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (obs !== hv) begin
                errors++; $display("FAIL %s stay_halted: got %b want %b", name, obs, hv);
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== ((instr[7:4] == 4'hD) || (instr[7:4] == 4'hE))) begin
            errors++; $display("FAIL %s illegal_flag: got %b want %b", name, illegal,
                               ((instr[7:4] == 4'hD) || (instr[7:4] == 4'hE)));
        end
`endif
        run = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL %s reset_exit: got %b want %b", name, obs, 13'd0);
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL %s illegal_clear: got %b want 0", name, illegal);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 13'd0) begin
            errors++; $display("FAIL %s idle_after_reset: got %b want %b", name, obs, 13'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h14, "alu_add");
        test_single(8'h2A, "alu_sub");
        test_single(8'h7E, "alu_shr");
        test_single(8'h8F, "imm_addi");
        test_single(8'h9F, "imm_andi");
        test_single(8'hA5, "imm_ldi");
        test_single(8'hB1, "mem_ld");
        test_single(8'hC1, "mem_st");
        test_single(8'h00, "nop");
`ifdef CTRL_ILLEGAL_TRAP_EN
        test_halt(8'hD0, "illegal_d");
        test_halt(8'hE3, "illegal_e");
`else
        test_single(8'hD0, "illegal_d_nop");
        test_single(8'hE3, "illegal_e_nop");
`endif
        test_back_to_back(60);
        test_halt(8'hF0, "halt");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
